ssc_sort_checker: RTL
=====================

# ssc_sort_checker

Post-sort verifier for the sort selection circuit (SSC). After the sort datapath has written memory, this block reads back words 0..len and confirms they are in non-decreasing unsigned order. It reports pass/fail, the first offending address and a violation count, and compresses every word read into a 16-bit MISR signature for BIST comparison. It is the read-side counterpart of the sort datapath's write path and shares the same single-port memory through the top-level address mux.

## Interface
- Parameters:
  - DATA_W, 16: memory word width.
  - ADDR_W, 8: memory address width.
  - MISR_SEED, 16'hFFFF: signature value loaded on start.
- Ports, clock and reset first:
  - clk  in  1: single clock, rising edge.
  - rst  in  1: reset, synchronous, active-high.
  - start  in  1: begin a check. Sampled only in IDLE.
  - len  in  ADDR_W: index of the last word to check. Words 0..len are read, so len+1 words in total.
  - mem_addr  out  ADDR_W: read address, registered.
  - mem_rd_en  out  1: read strobe, registered.
  - read_data  in  DATA_W: memory output, valid one cycle after address and strobe.
  - busy  out  1: high from the cycle after start is accepted until done.
  - done  out  1: one-cycle pulse when the check completes.
  - pass  out  1: 1 if no order violation was found.
  - fail_addr  out  ADDR_W: address k of the first word with data[k] < data[k-1]. Holds 0 when pass=1.
  - err_cnt  out  8: number of violations, saturating at 255.
  - signature  out  DATA_W: final MISR value.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE -> READ when start=1. On the same edge: latch len, clear err_cnt, set pass=1, clear fail_addr, load MISR_SEED.
  - READ: drive mem_addr=k and mem_rd_en=1 for k=0..len, incrementing k by one each cycle. After issuing address len, go to DRAIN.
  - DRAIN: one cycle with mem_rd_en=0, collecting the last word. Then go to DONE.
  - DONE: assert done for one cycle, then return to IDLE.
- Per-word processing, on the edge where word k is sampled:
  - Update the MISR with the word.
  - For k>0, compare the word with prev, the stored word k-1, as unsigned values. Equal values are legal.
  - On a violation: increment err_cnt (saturating at 255). If this is the first violation, latch fail_addr=k and clear pass.
  - Store the word as prev.
- Word 0 is never compared.
- MISR step: sig_next = ({sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000)) ^ read_data.
- pass, fail_addr, err_cnt and signature hold their values after done until the next accepted start.
- start while busy is ignored. len changes while busy are ignored.

## Timing
- Let E0 be the edge that samples start.
- Address k is driven after edge E_k. read_data for k is valid after E_{k+1} and is sampled at E_{k+2}.
- The last word is sampled at E_{len+2}. done is high in the cycle after E_{len+2}, i.e. len+3 cycles after start.
- busy goes high after E0 and goes low in the same cycle that done is high.
- len=0: one read, no compare. done is high in the cycle after E2, with pass=1 and err_cnt=0.
- len=255: the address counter is ADDR_W+1 bits wide, so the last address 255 does not wrap to 0 before DRAIN.
- rst asserted at any edge, including mid-READ: next state IDLE and all outputs return to reset values. No done pulse is produced.
- Reset values:
  - mem_addr=0, mem_rd_en=0, busy=0, done=0.
  - pass=0, fail_addr=0, err_cnt=0.
  - signature=MISR_SEED.

## Structure
- Shared package ssc_pkg holds:
  - the DATA_W and ADDR_W defaults;
  - the checker state enum (IDLE/READ/DRAIN/DONE);
  - MISR_POLY=16'h1021 and MISR_SEED.
- Sub-module ssc_misr16 contains the signature register, with inputs clk, rst, init, en, din and output sig. It is reused by the BIST wrapper.
- Everything else (FSM, address counter, prev register, comparator, error logic) lives in ssc_sort_checker.

## Test plan
- Sorted memory {1,2,3,4} with len=3, start pulsed -> done 6 cycles after start, pass=1, err_cnt=0, signature matches the reference model.
- Memory {5,3,7,2} with len=3 -> pass=0, fail_addr=1, err_cnt=2.
- Memory of all 16'h00AA with len=7 (equal values) -> pass=1, err_cnt=0.
- len=0 with word 16'hFFFF -> one read, pass=1, done 3 cycles after start, signature = model(MISR_SEED, 16'hFFFF).
- len=255 with descending data 255..0 -> addresses 0..255 issued with no wrap, err_cnt=255, fail_addr=1.
- rst at READ cycle 3, then a new start with sorted data -> no done from the aborted run, and the second run reports pass=1 with a clean signature.

Source files
------------

// File: rtl/ssc_pkg.sv
// Shared definitions for the sort selection circuit: default widths,
// the post-sort checker state encoding and the 16-bit MISR constants.
package ssc_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;

    localparam logic [15:0] MISR_POLY     = 16'h1021;
    localparam logic [15:0] MISR_SEED_DEF = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    // One MISR compression step: shift left, fold the polynomial in when
    // the top bit falls out, then mix in the new word.
    function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                              input logic [15:0] din);
        return ({sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000)) ^ din;
    endfunction

endpackage

// File: rtl/ssc_misr16.sv
// 16-bit multiple-input signature register. Loads SEED on reset or init and
// compresses din into the signature on every enabled cycle. Shared with the
// BIST wrapper.
module ssc_misr16
    import ssc_pkg::*;
#(
    parameter logic [15:0] SEED = MISR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [15:0] din,
    output logic [15:0] sig
);

    // Signature register: init wins over a compression step.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= SEED;
        end else if (init) begin
            sig <= SEED;
        end else if (en) begin
            sig <= misr_step(sig, din);
        end
    end

endmodule

// File: rtl/ssc_sort_checker.sv
// Post-sort verifier: reads words 0..len back from the shared memory, checks
// non-decreasing unsigned order, records the first offending address and a
// saturating violation count, and compresses every word into a MISR.
module ssc_sort_checker
    import ssc_pkg::*;
#(
    parameter int          DATA_W    = DATA_W_DEF,
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter logic [15:0] MISR_SEED = MISR_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [7:0]        err_cnt,
    output logic [DATA_W-1:0] signature
);

    // Saturating increment for the violation counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    chk_state_t        state;
    chk_state_t        state_next;
    // One bit wider than an address so that len=255 reaches 256 and stops
    // instead of wrapping back to 0.
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W-1:0] len_q;
    logic              accept;
    logic              issue_more;

    // Read-return pipeline: address and strobe delayed to line up with read_data.
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] prev_p1;
    logic              viol;

    assign accept     = (state == IDLE) && start;
    assign issue_more = (cnt <= {1'b0, len_q});

    assign busy = (state == READ) || (state == DRAIN);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: READ runs until every address 0..len is issued,
    // DRAIN waits for the final word, DONE is a single-cycle pulse.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = READ;
            READ:    if (!issue_more) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address generator: address 0 goes out on the accepting edge, then one
    // new address per cycle while READ still has words left to issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
        end else if (accept) begin
            cnt       <= {{ADDR_W{1'b0}}, 1'b1};
            mem_addr  <= '0;
            mem_rd_en <= 1'b1;
        end else if ((state == READ) && issue_more) begin
            cnt       <= cnt + {{ADDR_W{1'b0}}, 1'b1};
            mem_addr  <= cnt[ADDR_W-1:0];
            mem_rd_en <= 1'b1;
        end else begin
            mem_rd_en <= 1'b0;
        end
    end

    // Length is captured once per run so changes while busy have no effect.
    always_ff @(posedge clk) begin
        if (accept) begin
            len_q <= len;
        end
    end

    // Stage p1 control: read_data carries a valid word the cycle after a strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= mem_rd_en;
        end
    end

    // Stage p1 data: address of the returning word and the previous word.
    always_ff @(posedge clk) begin
        addr_p1 <= mem_addr;
        if (vld_p1) begin
            prev_p1 <= read_data;
        end
    end

    // Word 0 has no predecessor; equal neighbours are legal.
    assign viol = vld_p1 && (addr_p1 != '0) && (read_data < prev_p1);

    // Result registers: cleared on accept, first violation latches its
    // address and drops pass, every violation bumps the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass      <= 1'b0;
            fail_addr <= '0;
            err_cnt   <= 8'd0;
        end else if (accept) begin
            pass      <= 1'b1;
            fail_addr <= '0;
            err_cnt   <= 8'd0;
        end else if (viol) begin
            err_cnt <= sat_inc(err_cnt);
            if (pass) begin
                pass      <= 1'b0;
                fail_addr <= addr_p1;
            end
        end
    end

    ssc_misr16 #(
        .SEED (MISR_SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .init (accept),
        .en   (vld_p1),
        .din  (read_data),
        .sig  (signature)
    );

endmodule
